ooo_execute_dispatch: RTL
=========================

// Module: ooo_execute_dispatch
// PURPOSE
//  Execute-side receiver for the decode->execute bundle. It latches one decoded op
//  per cycle into an issue register and dispatches it to the arith, mult, div or
//  lsu scalar functional unit. It tracks per-unit occupancy and returns dec_ready
//  and per-unit busy flags to decode, which derives its stall_* signals from them.
// PARAMETERS
//  MUL_LATENCY  3   pipelined multiplier depth in cycles (>=1); one issue per cycle
//  DIV_LATENCY  17  iterative divider occupancy in cycles (>=2); non-pipelined
// PORTS
//  CLK           in   1   clock
//  nRST          in   1   asynchronous reset, active low
//  dec_valid     in   1   decode presents a valid op this cycle
//  dec_ready     out  1   op accepted when dec_valid && dec_ready
//  dec_sfu_type  in   2   target unit (scalar_fu_t: ARITH_S/MUL_S/DIV_S/LOADSTORE_S)
//  dec_instr     in   32  raw instruction word
//  dec_pc        in   32  instruction PC
//  dec_port_a    in   32  operand A
//  dec_port_b    in   32  operand B
//  dec_imm       in   32  immediate
//  flush         in   1   squash the latched op and any in-flight divide
//  lsu_done      in   1   lsu completion pulse
//  iss_valid     out  4   one-hot issue strobe, bit index = scalar_fu_t
//  iss_instr     out  32  latched instr  } held stable while iss_valid is 0
//  iss_pc        out  32  latched pc     } or the op is blocked
//  iss_port_a    out  32  latched A
//  iss_port_b    out  32  latched B
//  iss_imm       out  32  latched immediate
//  busy_mul      out  1   multiplier pipeline holds an op (informational)
//  busy_div      out  1   divider occupied
//  busy_lsu      out  1   lsu request outstanding
//  mul_wb_valid  out  1   multiply result due this cycle (pipe tail)
//  div_wb_valid  out  1   divide result due this cycle
// BEHAVIOUR
//  Reset (nRST low, async): the issue register is invalid and its payload is 0.
//   iss_valid=0, all busy_*=0, the div counter is 0, the mul shift register is 0,
//   mul_wb_valid=0, div_wb_valid=0. dec_ready is 1 after reset.
//  Issue register: held=valid bit plus payload plus sfu_type.
//   blocked  = held && ((type==DIV_S && busy_div) || (type==LOADSTORE_S && busy_lsu))
//   fire     = held && !blocked && !flush
//   dec_ready= !held || fire   (combinational; bypass-free, one-cycle latency)
//   iss_valid[type]=fire; arith and mul never block.
//   On accept, load the payload and set held. Else on fire, clear held.
//   On flush, clear held and ignore dec_valid that cycle (dec_ready is forced to 0).
//  Mult: a MUL_LATENCY-bit valid shift register; bit0 is set on a mul fire and
//   shifts each cycle. mul_wb_valid = MSB. busy_mul = |shift register.
//   Flush does not clear it, because older ops are architecturally committed.
//  Div counter (width clog2(DIV_LATENCY)+1): on a div fire, load DIV_LATENCY.
//   Decrement while nonzero. div_wb_valid pulses on the 1->0 step.
//   busy_div = counter!=0. A div fire in the same cycle as div_wb_valid is legal:
//   busy_div drops combinationally that cycle.
//   Flush zeroes the counter and suppresses div_wb_valid that cycle.
//  LSU: busy_lsu sets on an lsu fire and clears on lsu_done.
//   If lsu_done and an lsu fire occur in the same cycle, busy_lsu stays 1.
//   lsu_done while not busy is ignored. Flush never clears busy_lsu, because a
//   memory access cannot be cancelled.
//  Blocked lsu/div ops are released the same cycle busy drops: lsu_done
//   combinationally unblocks. dec_valid may fall without acceptance, and no data
//   is lost.
//  No arithmetic on payload; all widths are pass-through 32 bits.
// STRUCTURE
//  Shared package (ooo_dispatch_pkg or the existing types pkg): scalar_fu_t with a
//   fixed encoding (ARITH_S=0, MUL_S=1, DIV_S=2, LOADSTORE_S=3), a dispatch_payload_t
//   packed struct {instr,pc,port_a,port_b,imm,sfu_type}, and the default latency
//   localparams.
//  One natural sub-module: ooo_fu_occupancy, holding the div counter, the mul shift
//   register and the lsu busy flop. Top level = issue register + fire/ready logic.
// TESTING
//  1 Back-to-back arith x4 with dec_valid=1 -> dec_ready=1 every cycle; iss_valid=4'b0001
//    each cycle from cycle 1; payload matches the 1-cycle-delayed input.
//  2 DIV(DIV_LATENCY=17) then DIV -> first fires at t, div_wb_valid at t+17; second held,
//    dec_ready=0, fires at t+17; no op lost.
//  3 LSU fire, then LSU; lsu_done at t+5 -> second fires at t+5; busy_lsu stays 1.
//  4 MUL x3 consecutive (MUL_LATENCY=3) -> mul_wb_valid high cycles t+3..t+5.
//  5 flush during a blocked DIV with 9 cycles left -> held cleared, busy_div=0 next
//    cycle, no div_wb_valid; busy_lsu unchanged.
//  6 nRST asserted mid-divide, async -> all outputs 0 immediately; dec_ready=1 after release.

Source files
------------

// File: rtl/ooo_dispatch_pkg.sv
// ooo_dispatch_pkg: shared types and default latencies for execute dispatch
package ooo_dispatch_pkg;

    typedef enum logic [1:0] {
        ARITH_S     = 2'd0,
        MUL_S       = 2'd1,
        DIV_S       = 2'd2,
        LOADSTORE_S = 2'd3
    } scalar_fu_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] port_a;
        logic [31:0] port_b;
        logic [31:0] imm;
        scalar_fu_t  sfu_type;
    } dispatch_payload_t;

    localparam int MUL_LATENCY_DEF = 3;
    localparam int DIV_LATENCY_DEF = 17;

endpackage

// File: rtl/ooo_fu_occupancy.sv
// ooo_fu_occupancy: tracks multiplier pipe, divider countdown and lsu outstanding flag
module ooo_fu_occupancy
    import ooo_dispatch_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
    input  logic CLK,
    input  logic nRST,
    input  logic flush,
    input  logic mul_fire,
    input  logic div_fire,
    input  logic lsu_fire,
    input  logic lsu_done,
    output logic busy_mul,
    output logic busy_div,
    output logic busy_lsu,
    output logic lsu_block,
    output logic mul_wb_valid,
    output logic div_wb_valid
);

    localparam int CW = $clog2(DIV_LATENCY) + 1;

    logic [MUL_LATENCY-1:0] mul_sr;
    logic [CW-1:0]          div_cnt;
    logic                   lsu_q;

    assign mul_wb_valid = mul_sr[MUL_LATENCY-1];
    assign busy_mul     = |mul_sr;
    assign div_wb_valid = (div_cnt == CW'(1)) && !flush;
    // The final count cycle is the writeback cycle, so the divider is free for a new op then.
    assign busy_div     = div_cnt > CW'(1);
    assign busy_lsu     = lsu_q;
    assign lsu_block    = lsu_q && !lsu_done;

    // Advance the mul valid pipe, count down the divider, and track the lsu request.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mul_sr  <= '0;
            div_cnt <= '0;
            lsu_q   <= 1'b0;
        end else begin
            mul_sr  <= (mul_sr << 1) | MUL_LATENCY'(mul_fire);
            div_cnt <= flush ? '0 : div_fire ? CW'(DIV_LATENCY) : (div_cnt != '0) ? div_cnt - CW'(1) : div_cnt;
            lsu_q   <= lsu_fire ? 1'b1 : lsu_done ? 1'b0 : lsu_q;
        end
    end

endmodule

// File: rtl/ooo_execute_dispatch.sv
// ooo_execute_dispatch: issue register that accepts decoded ops and dispatches them to scalar units
module ooo_execute_dispatch
    import ooo_dispatch_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  scalar_fu_t  dec_sfu_type,
    input  logic [31:0] dec_instr,
    input  logic [31:0] dec_pc,
    input  logic [31:0] dec_port_a,
    input  logic [31:0] dec_port_b,
    input  logic [31:0] dec_imm,
    input  logic        flush,
    input  logic        lsu_done,
    output logic [3:0]  iss_valid,
    output logic [31:0] iss_instr,
    output logic [31:0] iss_pc,
    output logic [31:0] iss_port_a,
    output logic [31:0] iss_port_b,
    output logic [31:0] iss_imm,
    output logic        busy_mul,
    output logic        busy_div,
    output logic        busy_lsu,
    output logic        mul_wb_valid,
    output logic        div_wb_valid
);

    dispatch_payload_t pl;
    logic              held;
    logic              lsu_block;
    logic              blocked;
    logic              fire;
    logic              accept;

    assign blocked    = held && ((pl.sfu_type == DIV_S && busy_div) || (pl.sfu_type == LOADSTORE_S && lsu_block));
    assign fire       = held && !blocked && !flush;
    assign dec_ready  = !flush && (!held || fire);
    assign accept     = dec_valid && dec_ready;
    assign iss_valid  = fire ? 4'b0001 << pl.sfu_type : 4'b0000;
    assign iss_instr  = pl.instr;
    assign iss_pc     = pl.pc;
    assign iss_port_a = pl.port_a;
    assign iss_port_b = pl.port_b;
    assign iss_imm    = pl.imm;

    // Load a new op on accept; otherwise drop it once issued or squashed, keeping the payload stable.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            held <= 1'b0;
            pl   <= '0;
        end else if (accept) begin
            held <= 1'b1;
            pl   <= '{dec_instr, dec_pc, dec_port_a, dec_port_b, dec_imm, dec_sfu_type};
        end else if (fire || flush) begin
            held <= 1'b0;
        end
    end

    ooo_fu_occupancy #(
        .MUL_LATENCY(MUL_LATENCY),
        .DIV_LATENCY(DIV_LATENCY)
    ) u_occ (
        .CLK         (CLK),
        .nRST        (nRST),
        .flush       (flush),
        .mul_fire    (iss_valid[MUL_S]),
        .div_fire    (iss_valid[DIV_S]),
        .lsu_fire    (iss_valid[LOADSTORE_S]),
        .lsu_done    (lsu_done),
        .busy_mul    (busy_mul),
        .busy_div    (busy_div),
        .busy_lsu    (busy_lsu),
        .lsu_block   (lsu_block),
        .mul_wb_valid(mul_wb_valid),
        .div_wb_valid(div_wb_valid)
    );

endmodule
